// File: rtl/seq_alu_pkg.sv
// rtl/seq_alu_pkg.sv - opcodes, FSM states and flag bit positions shared by seq_alu and its iterative datapath
package seq_alu_pkg;

  typedef enum logic [4:0] {
    OP_NOP = 5'd0,
    OP_LD  = 5'd1,
    OP_NOT = 5'd2,
    OP_XOR = 5'd3,
    OP_OR  = 5'd4,
    OP_AND = 5'd5,
    OP_ADD = 5'd6,
    OP_SUB = 5'd7,
    OP_INC = 5'd8,
    OP_DEC = 5'd9,
    OP_RR  = 5'd10,
    OP_RL  = 5'd11,
    OP_SHL = 5'd12,
    OP_SHR = 5'd13,
    OP_ROL = 5'd14,
    OP_ROR = 5'd15,
    OP_MUL = 5'd16
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int FLAG_Z = 0;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 2;
  localparam int FLAG_N = 3;

  // Any code outside the defined set executes as NOP.
  function automatic alu_op_e decode_op(input logic [31:0] code);
    if (code <= 32'd16) begin
      return alu_op_e'(code[4:0]);
    end
    return OP_NOP;
  endfunction

endpackage

// File: rtl/seq_alu_iter.sv
// rtl/seq_alu_iter.sv - one-bit-per-cycle shifter/rotator and shift-add multiplier with iteration counter
module seq_alu_iter
  import seq_alu_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int SHAMT_WIDTH = $clog2(DATA_WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_start,
  input  logic                  i_step,
  input  alu_op_e               i_op,
  input  logic [DATA_WIDTH-1:0] i_a,
  input  logic [DATA_WIDTH-1:0] i_b,
  output logic                  o_last,
  output logic [DATA_WIDTH-1:0] o_lo,
  output logic [DATA_WIDTH-1:0] o_hi,
  output logic                  o_carry
);
  localparam int MSB       = DATA_WIDTH - 1;
  localparam int CNT_WIDTH = $clog2(DATA_WIDTH) + 1;

  alu_op_e               r_op;
  logic [DATA_WIDTH-1:0] r_acc;
  logic [DATA_WIDTH-1:0] r_hi;
  logic [DATA_WIDTH-1:0] r_mcand;
  logic [CNT_WIDTH-1:0]  r_cnt;
  logic                  r_carry;
  logic                  r_noshift;

  logic [SHAMT_WIDTH-1:0] w_shamt;
  logic [CNT_WIDTH-1:0]   w_load_cnt;
  logic [DATA_WIDTH:0]    w_sum;

  assign w_shamt = i_b[SHAMT_WIDTH-1:0];
  assign w_sum   = {1'b0, r_hi} + {1'b0, r_mcand};
  assign o_last  = i_step && (r_cnt == CNT_WIDTH'(1));

  // Single-cycle ops still load a count of one so EXEC ends uniformly on o_last.
  always_comb begin
    w_load_cnt = CNT_WIDTH'(1);
    case (i_op)
      OP_MUL: w_load_cnt = CNT_WIDTH'(DATA_WIDTH);
      OP_SHL, OP_SHR, OP_ROL, OP_ROR:
        if (w_shamt != '0) w_load_cnt = CNT_WIDTH'(w_shamt);
      default: ;
    endcase
  end

  // Multiplier keeps {hi, acc} as the partial product with the multiplier draining out of acc.
  always_comb begin
    o_lo    = r_acc;
    o_hi    = r_hi;
    o_carry = r_carry;
    case (r_op)
      OP_MUL: begin
        if (r_acc[0]) begin
          o_hi = w_sum[DATA_WIDTH:1];
          o_lo = {w_sum[0], r_acc[MSB:1]};
        end else begin
          o_hi = {1'b0, r_hi[MSB:1]};
          o_lo = {r_hi[0], r_acc[MSB:1]};
        end
      end
      OP_SHL: if (!r_noshift) begin
        o_lo    = {r_acc[MSB-1:0], 1'b0};
        o_carry = r_acc[MSB];
      end
      OP_SHR: if (!r_noshift) begin
        o_lo    = {1'b0, r_acc[MSB:1]};
        o_carry = r_acc[0];
      end
      OP_ROL: if (!r_noshift) begin
        o_lo    = {r_acc[MSB-1:0], r_acc[MSB]};
        o_carry = r_acc[MSB];
      end
      OP_ROR: if (!r_noshift) begin
        o_lo    = {r_acc[0], r_acc[MSB:1]};
        o_carry = r_acc[0];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_op      <= OP_NOP;
      r_acc     <= '0;
      r_hi      <= '0;
      r_mcand   <= '0;
      r_cnt     <= '0;
      r_carry   <= 1'b0;
      r_noshift <= 1'b0;
    end else if (i_start) begin
      r_op      <= i_op;
      r_acc     <= (i_op == OP_MUL) ? i_b : i_a;
      r_hi      <= '0;
      r_mcand   <= i_a;
      r_cnt     <= w_load_cnt;
      r_carry   <= 1'b0;
      r_noshift <= (w_shamt == '0);
    end else if (i_step && (r_cnt != '0)) begin
      r_acc   <= o_lo;
      r_hi    <= o_hi;
      r_carry <= o_carry;
      r_cnt   <= r_cnt - CNT_WIDTH'(1);
    end
  end

endmodule

// File: rtl/seq_alu.sv
// rtl/seq_alu.sv - sequential ALU: valid/ready request FSM, single-cycle ops, iterative shift/multiply via seq_alu_iter
module seq_alu
  import seq_alu_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int OP_WIDTH    = 5,
  parameter int SHAMT_WIDTH = $clog2(DATA_WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in1_acc,
  input  logic [DATA_WIDTH-1:0] in2_reg,
  input  logic [OP_WIDTH-1:0]   operation,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic [DATA_WIDTH-1:0] data_hi,
  output logic [3:0]            flags
);
  localparam int MSB = DATA_WIDTH - 1;

  state_e                r_state;
  state_e                w_state_nxt;
  alu_op_e               r_op;
  logic [DATA_WIDTH-1:0] r_in1;
  logic [DATA_WIDTH-1:0] r_in2;
  logic [DATA_WIDTH-1:0] r_data_out;
  logic [DATA_WIDTH-1:0] r_data_hi;
  logic [3:0]            r_flags;

  alu_op_e               w_op_in;
  logic                  w_accept;
  logic                  w_exec;
  logic                  w_iter_last;
  logic [DATA_WIDTH-1:0] w_iter_lo;
  logic [DATA_WIDTH-1:0] w_iter_hi;
  logic                  w_iter_carry;
  logic [DATA_WIDTH-1:0] w_b2;
  logic [DATA_WIDTH:0]   w_sum;
  logic [DATA_WIDTH:0]   w_diff;
  logic [DATA_WIDTH-1:0] w_res;
  logic [DATA_WIDTH-1:0] w_hi;
  logic                  w_c;
  logic                  w_v;
  logic [3:0]            w_flags;

  assign w_op_in  = decode_op(32'(operation));
  assign w_accept = in_valid && (r_state == ST_IDLE);
  assign w_exec   = (r_state == ST_EXEC);

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (in_valid)    w_state_nxt = ST_EXEC;
      ST_EXEC: if (w_iter_last) w_state_nxt = ST_DONE;
      ST_DONE: if (out_ready)   w_state_nxt = ST_IDLE;
      default:                  w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (r_state == ST_IDLE);
    out_valid = (r_state == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_op  <= OP_NOP;
      r_in1 <= '0;
      r_in2 <= '0;
    end else if (w_accept) begin
      r_op  <= w_op_in;
      r_in1 <= in1_acc;
      r_in2 <= in2_reg;
    end
  end

  seq_alu_iter #(
    .DATA_WIDTH (DATA_WIDTH),
    .SHAMT_WIDTH(SHAMT_WIDTH)
  ) u_iter (
    .clk    (clk),
    .rst    (rst),
    .i_start(w_accept),
    .i_step (w_exec),
    .i_op   (w_op_in),
    .i_a    (in1_acc),
    .i_b    (in2_reg),
    .o_last (w_iter_last),
    .o_lo   (w_iter_lo),
    .o_hi   (w_iter_hi),
    .o_carry(w_iter_carry)
  );

  // INC/DEC share the ADD/SUB paths with a constant subtrahend/addend of one.
  assign w_b2   = ((r_op == OP_INC) || (r_op == OP_DEC)) ? DATA_WIDTH'(1) : r_in2;
  assign w_sum  = {1'b0, r_in1} + {1'b0, w_b2};
  assign w_diff = {1'b0, r_in1} - {1'b0, w_b2};

  always_comb begin
    w_res = r_in1;
    w_hi  = '0;
    w_c   = 1'b0;
    w_v   = 1'b0;
    case (r_op)
      OP_LD:  w_res = r_in2;
      OP_NOT: w_res = ~r_in1;
      OP_XOR: w_res = r_in1 ^ r_in2;
      OP_OR:  w_res = r_in1 | r_in2;
      OP_AND: w_res = r_in1 & r_in2;
      OP_ADD, OP_INC: begin
        w_res = w_sum[MSB:0];
        w_c   = w_sum[DATA_WIDTH];
        w_v   = (r_in1[MSB] == w_b2[MSB]) && (w_sum[MSB] != r_in1[MSB]);
      end
      OP_SUB, OP_DEC: begin
        w_res = w_diff[MSB:0];
        w_c   = w_diff[DATA_WIDTH];
        w_v   = (r_in1[MSB] != w_b2[MSB]) && (w_diff[MSB] != r_in1[MSB]);
      end
      OP_RR: begin
        w_res = {1'b0, r_in1[MSB:1]};
        w_c   = r_in1[0];
      end
      OP_RL: begin
        w_res = {r_in1[MSB-1:0], 1'b0};
        w_c   = r_in1[MSB];
      end
      OP_SHL, OP_SHR, OP_ROL, OP_ROR: begin
        w_res = w_iter_lo;
        w_c   = w_iter_carry;
      end
      OP_MUL: begin
        w_res = w_iter_lo;
        w_hi  = w_iter_hi;
        w_c   = |w_iter_hi;
      end
      default: ;
    endcase
    w_flags         = '0;
    w_flags[FLAG_N] = w_res[MSB];
    w_flags[FLAG_V] = w_v;
    w_flags[FLAG_C] = w_c;
    w_flags[FLAG_Z] = (w_res == '0) && (w_hi == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_data_out <= '0;
      r_data_hi  <= '0;
      r_flags    <= '0;
    end else if (w_exec && w_iter_last) begin
      r_data_out <= w_res;
      r_data_hi  <= w_hi;
      r_flags    <= w_flags;
    end
  end

  assign data_out = r_data_out;
  assign data_hi  = r_data_hi;
  assign flags    = r_flags;

endmodule
